// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, ALU functions, conditions, status, E->M bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package y86_pkg;

  localparam int WORD_W = 64;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // ALU function codes
  localparam logic [1:0] ALUADD = 2'd0;
  localparam logic [1:0] ALUSUB = 2'd1;
  localparam logic [1:0] ALUAND = 2'd2;
  localparam logic [1:0] ALUXOR = 2'd3;

  // Jump / cmov condition codes
  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  // Status codes
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  // E->M pipeline register contents
  typedef struct packed {
    logic [2:0]        stat;
    logic [3:0]        icode;
    logic              cnd;
    logic [WORD_W-1:0] val_e;
    logic [WORD_W-1:0] val_a;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
  } em_t;

  localparam em_t EM_BUBBLE = '{stat: SAOK, icode: INOP, cnd: 1'b0,
                                val_e: '0, val_a: '0,
                                dst_e: RNONE, dst_m: RNONE};

endpackage

// File: rtl/alu.sv
// Y86-64 ALU: add, sub (a - b), and, xor with {ZF,SF,OF} for the result.
// Latency: purely combinational.
// Backpressure: none.
module alu
  import y86_pkg::*;
(
  input  logic [WORD_W-1:0] alu_a,
  input  logic [WORD_W-1:0] alu_b,
  input  logic [1:0]        alu_fn,
  output logic [WORD_W-1:0] val_e,
  output logic [2:0]        cc_new
);

  logic of;

  // Result and signed-overflow flag per function
  always_comb begin
    val_e = '0;
    of    = 1'b0;
    unique case (alu_fn)
      ALUADD: begin
        val_e = alu_a + alu_b;
        of    = (alu_a[WORD_W-1] == alu_b[WORD_W-1]) && (val_e[WORD_W-1] != alu_a[WORD_W-1]);
      end
      ALUSUB: begin
        val_e = alu_a - alu_b;
        of    = (alu_a[WORD_W-1] != alu_b[WORD_W-1]) && (val_e[WORD_W-1] != alu_a[WORD_W-1]);
      end
      ALUAND: val_e = alu_a & alu_b;
      default: val_e = alu_a ^ alu_b;
    endcase
  end

  assign cc_new = {(val_e == '0), val_e[WORD_W-1], of};

endmodule

// File: rtl/exec_stage_cc_cond.sv
// Condition-code register with exception-gated update, plus jump/cmov condition evaluation.
// Latency: cnd combinational from the current CC; CC updates 1 cycle after set conditions.
// Backpressure: none; CC ignores pipeline stalls, only set gating and reset affect it.
module cc_cond
  import y86_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] icode,
  input  logic [3:0] ifun,
  input  logic [2:0] e_stat,
  input  logic [2:0] m_stat,
  input  logic [2:0] w_stat,
  input  logic [2:0] cc_new,
  output logic [2:0] cc,
  output logic       cnd
);

  logic set_cc;
  logic zf, sf, of;

  function automatic logic is_exc(input logic [2:0] s);
    return (s == SHLT) || (s == SADR) || (s == SINS);
  endfunction

  // Only an OPq that is itself fine and has no older faulting instruction may touch CC
  assign set_cc = (icode == IOPQ) && (e_stat == SAOK) && !is_exc(m_stat) && !is_exc(w_stat);

  // CC register, reset to ZF=1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cc <= 3'b100;
    else if (set_cc) cc <= cc_new;
  end

  assign {zf, sf, of} = cc;

  // Condition from pre-update CC
  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = (sf ^ of) | zf;
      C_L:     cnd = sf ^ of;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~(sf ^ of);
      C_G:     cnd = ~(sf ^ of) & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// Y86-64 execute stage: ALU operand select, CC/conditions, E->M pipeline register.
// Latency: e_* combinational; M_* and cc registered, 1 cycle after E inputs.
// Backpressure: M_stall holds the E->M register, M_bubble (higher priority) loads a NOP.
module exec_stage #(
  parameter int         W     = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   E_stat,
  input  logic [3:0]   E_icode,
  input  logic [3:0]   E_ifun,
  input  logic [W-1:0] E_valA,
  input  logic [W-1:0] E_valB,
  input  logic [W-1:0] E_valC,
  input  logic [3:0]   E_dstE,
  input  logic [3:0]   E_dstM,
  input  logic [2:0]   m_stat,
  input  logic [2:0]   W_stat,
  input  logic         M_stall,
  input  logic         M_bubble,
  output logic [W-1:0] e_valE,
  output logic [3:0]   e_dstE,
  output logic         e_Cnd,
  output logic [2:0]   cc,
  output logic [2:0]   M_stat,
  output logic [3:0]   M_icode,
  output logic         M_Cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM
);

  import y86_pkg::*;

  logic [W-1:0] alu_a, alu_b;
  logic [1:0]   alu_fn;
  logic [2:0]   cc_new;
  em_t          m_d, m_q;

  // Operand and function select by instruction class
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_fn = ALUADD;
    case (E_icode)
      IRRMOVQ:          alu_a = E_valA;
      IIRMOVQ:          alu_a = E_valC;
      IRMMOVQ, IMRMOVQ: begin alu_a = E_valC; alu_b = E_valB; end
      IOPQ:             begin alu_a = E_valB; alu_b = E_valA; alu_fn = E_ifun[1:0]; end
      ICALL, IPUSHQ:    begin alu_a = E_valB; alu_b = -W'(8); end
      IRET, IPOPQ:      begin alu_a = E_valB; alu_b = W'(8); end
      default:          ;
    endcase
  end

  alu u_alu (
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_fn (alu_fn),
    .val_e  (e_valE),
    .cc_new (cc_new)
  );

  cc_cond u_cc_cond (
    .clk    (clk),
    .rst_n  (rst_n),
    .icode  (E_icode),
    .ifun   (E_ifun),
    .e_stat (E_stat),
    .m_stat (m_stat),
    .w_stat (W_stat),
    .cc_new (cc_new),
    .cc     (cc),
    .cnd    (e_Cnd)
  );

  // A cmov whose condition fails must not write back
  assign e_dstE = ((E_icode == IRRMOVQ) && !e_Cnd) ? RNONE : E_dstE;

  always_comb begin
    m_d.stat  = E_stat;
    m_d.icode = E_icode;
    m_d.cnd   = e_Cnd;
    m_d.val_e = e_valE;
    m_d.val_a = E_valA;
    m_d.dst_e = e_dstE;
    m_d.dst_m = E_dstM;
  end

  // E->M register: bubble beats stall beats load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        m_q <= EM_BUBBLE;
    else if (M_bubble) m_q <= EM_BUBBLE;
    else if (!M_stall) m_q <= m_d;
  end

  assign M_stat  = m_q.stat;
  assign M_icode = m_q.icode;
  assign M_Cnd   = m_q.cnd;
  assign M_valE  = m_q.val_e;
  assign M_valA  = m_q.val_a;
  assign M_dstE  = m_q.dst_e;
  assign M_dstM  = m_q.dst_m;

endmodule

// File: tb/tb_exec_stage.sv
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  E_stat, m_stat, W_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valA, E_valB, E_valC;
  logic        M_stall, M_bubble;
  logic [63:0] e_valE, M_valE, M_valA;
  logic [3:0]  e_dstE, M_icode, M_dstE, M_dstM;
  logic        e_Cnd, M_Cnd;
  logic [2:0]  cc, M_stat;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  exec_stage dut (
    .clk(clk), .rst_n(rst_n),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat),
    .M_stall(M_stall), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd), .cc(cc),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  // ---------------- reference model (arithmetic from the instruction rules) ----------------
  function automatic logic [63:0] ref_vale(input logic [3:0] ic, input logic [3:0] fn,
                                           input logic [63:0] va, vb, vc);
    case (ic)
      4'h2:       return va;
      4'h3:       return vc;
      4'h4, 4'h5: return vc + vb;
      4'h6: case (fn[1:0])
              2'd0: return vb + va;
              2'd1: return vb - va;
              2'd2: return vb & va;
              default: return vb ^ va;
            endcase
      4'h8, 4'hA: return vb - 64'd8;
      4'h9, 4'hB: return vb + 64'd8;
      default:    return 64'd0;
    endcase
  endfunction

  function automatic logic [2:0] ref_flags(input logic [3:0] fn, input logic [63:0] va, vb);
    logic signed [64:0] wide;
    logic [63:0] r;
    logic of;
    r  = ref_vale(4'h6, fn, va, vb, 64'd0);
    of = 1'b0;
    if (fn[1:0] == 2'd0) begin
      wide = $signed({vb[63], vb}) + $signed({va[63], va});
      of = wide[64] != wide[63];
    end else if (fn[1:0] == 2'd1) begin
      wide = $signed({vb[63], vb}) - $signed({va[63], va});
      of = wide[64] != wide[63];
    end
    return {r == 64'd0, r[63], of};
  endfunction

  function automatic logic ref_cnd(input logic [3:0] fn, input logic [2:0] c);
    logic zf, lt;
    zf = c[2];
    lt = c[1] != c[0];
    case (fn)
      4'd0: return 1'b1;
      4'd1: return lt || zf;
      4'd2: return lt;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !lt;
      4'd6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic bad(input logic [2:0] s);
    return s == 3'd2 || s == 3'd3 || s == 3'd4;
  endfunction

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic drive(input logic [3:0] ic, fn, input logic [63:0] va, vb, vc,
                       input logic [3:0] de, dm, input logic [2:0] es, ms, ws);
    E_icode = ic; E_ifun = fn; E_valA = va; E_valB = vb; E_valC = vc;
    E_dstE = de; E_dstM = dm; E_stat = es; m_stat = ms; W_stat = ws;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; M_stall = 1'b0; M_bubble = 1'b0;
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 3'd1, 3'd1, 3'd1);
    repeat (2) tick;
    checks++; if (cc !== 3'b100) $display("FAIL reset_cc: got %b want 100", cc); else passed++;
    checks++; if ({M_stat, M_icode, M_dstE, M_dstM} !== {3'd1, 4'h1, 4'hF, 4'hF})
      $display("FAIL reset_m: got stat=%0d icode=%0h dstE=%0h dstM=%0h want 1 1 f f", M_stat, M_icode, M_dstE, M_dstM);
    else passed++;
    checks++; if (M_valE !== 64'd0) $display("FAIL reset_valE: got %h want 0", M_valE); else passed++;
    @(negedge clk); rst_n = 1'b1;
    tick;
    drive(4'h3, 4'h0, 64'd0, 64'd0, 64'h10, 4'd3, 4'hF, 3'd1, 3'd1, 3'd1);
    tick;
    checks++; if (M_valE !== 64'h10 || M_dstE !== 4'd3)
      $display("FAIL irmovq_load: got valE=%h dstE=%0h want 10 3", M_valE, M_dstE);
    else passed++;
  endtask

  task automatic test_flags;
    drive(4'h6, 4'h1, 64'd7, 64'd5, 64'd0, 4'd1, 4'hF, 3'd1, 3'd1, 3'd1);
    #2;
    checks++; if (e_valE !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL sub_valE: got %h want fffffffffffffffe", e_valE); else passed++;
    tick;
    checks++; if (cc !== 3'b010) $display("FAIL sub_cc: got %b want 010", cc); else passed++;
    drive(4'h6, 4'h3, 64'd9, 64'd9, 64'd0, 4'd1, 4'hF, 3'd1, 3'd1, 3'd1);
    #2;
    checks++; if (e_valE !== 64'd0) $display("FAIL xor_valE: got %h want 0", e_valE); else passed++;
    tick;
    checks++; if (cc !== 3'b100) $display("FAIL xor_cc: got %b want 100", cc); else passed++;
  endtask

  task automatic test_conditions;
    drive(4'h6, 4'h1, 64'd7, 64'd5, 64'd0, 4'd1, 4'hF, 3'd1, 3'd1, 3'd1);
    tick;
    drive(4'h2, 4'h2, 64'h77, 64'd0, 64'd0, 4'd4, 4'hF, 3'd1, 3'd1, 3'd1);
    #2;
    checks++; if (e_Cnd !== 1'b1 || e_dstE !== 4'd4)
      $display("FAIL cmovl: got cnd=%b dstE=%0h want 1 4", e_Cnd, e_dstE);
    else passed++;
    tick;
    drive(4'h2, 4'h5, 64'h77, 64'd0, 64'd0, 4'd4, 4'hF, 3'd1, 3'd1, 3'd1);
    #2;
    checks++; if (e_Cnd !== 1'b0 || e_dstE !== 4'hF)
      $display("FAIL cmovge: got cnd=%b dstE=%0h want 0 f", e_Cnd, e_dstE);
    else passed++;
    tick;
    checks++; if (M_dstE !== 4'hF || M_Cnd !== 1'b0)
      $display("FAIL cmovge_m: got dstE=%0h cnd=%b want f 0", M_dstE, M_Cnd);
    else passed++;
  endtask

  task automatic test_exceptions;
    // cc is 010 here; an add producing zero would otherwise set 100
    drive(4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 4'd1, 4'hF, 3'd1, 3'd3, 3'd1);
    tick;
    checks++; if (cc !== 3'b010) $display("FAIL exc_mstat: got %b want 010", cc); else passed++;
    drive(4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 4'd1, 4'hF, 3'd1, 3'd1, 3'd2);
    tick;
    checks++; if (cc !== 3'b010) $display("FAIL exc_wstat: got %b want 010", cc); else passed++;
    drive(4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 4'd1, 4'hF, 3'd4, 3'd1, 3'd1);
    tick;
    checks++; if (cc !== 3'b010) $display("FAIL exc_estat: got %b want 010", cc); else passed++;
  endtask

  task automatic test_stack;
    drive(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'd4, 4'hF, 3'd1, 3'd1, 3'd1);
    tick;
    checks++; if (M_valE !== 64'hF8) $display("FAIL pushq: got %h want f8", M_valE); else passed++;
    drive(4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 4'd4, 4'd5, 3'd1, 3'd1, 3'd1);
    tick;
    checks++; if (M_valE !== 64'h108) $display("FAIL popq: got %h want 108", M_valE); else passed++;
  endtask

  task automatic test_controls;
    drive(4'h3, 4'h0, 64'h33, 64'd0, 64'h55, 4'd2, 4'hF, 3'd1, 3'd1, 3'd1);
    tick;
    M_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(4'h3, 4'h0, 64'h99, 64'd0, 64'hAA + i, 4'd6, 4'd7, 3'd1, 3'd1, 3'd1);
      tick;
      checks++; if (M_valE !== 64'h55 || M_dstE !== 4'd2 || M_valA !== 64'h33)
        $display("FAIL stall_hold%0d: got valE=%h dstE=%0h valA=%h want 55 2 33", i, M_valE, M_dstE, M_valA);
      else passed++;
    end
    M_bubble = 1'b1;
    tick;
    checks++; if ({M_icode, M_dstE, M_dstM, M_Cnd} !== {4'h1, 4'hF, 4'hF, 1'b0} || M_valE !== 64'd0)
      $display("FAIL stall_bubble: got icode=%0h dstE=%0h dstM=%0h cnd=%b valE=%h want 1 f f 0 0", M_icode, M_dstE, M_dstM, M_Cnd, M_valE);
    else passed++;
    M_bubble = 1'b0; M_stall = 1'b0;
    drive(4'h6, 4'h1, 64'd7, 64'd5, 64'h0, 4'd3, 4'hF, 3'd1, 3'd1, 3'd1);
    tick;
    M_stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({M_icode, M_dstE, M_dstM} !== {4'h1, 4'hF, 4'hF} || M_valE !== 64'd0 || cc !== 3'b100)
      $display("FAIL reset_midstall: got icode=%0h dstE=%0h dstM=%0h valE=%h cc=%b want 1 f f 0 100", M_icode, M_dstE, M_dstM, M_valE, cc);
    else passed++;
    @(negedge clk); rst_n = 1'b1; M_stall = 1'b0;
    drive(4'h3, 4'h0, 64'd0, 64'd0, 64'h42, 4'd8, 4'hF, 3'd1, 3'd1, 3'd1);
    tick;
    checks++; if (M_valE !== 64'h42 || M_icode !== 4'h3)
      $display("FAIL load_after_reset: got valE=%h icode=%0h want 42 3", M_valE, M_icode);
    else passed++;
  endtask

  task automatic test_random;
    logic [2:0]  mcc;
    logic [84:0] exp_m, got_m;
    logic [63:0] ev;
    logic        ec;
    logic [3:0]  ed;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    mcc   = 3'b100;
    exp_m = {3'd1, 4'h1, 1'b0, 64'd0, 4'hF, 4'hF};
    tick;
    for (int n = 0; n < 300; n++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 9)),
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            4'($urandom), 4'($urandom),
            ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 4)) : 3'd1,
            ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 4)) : 3'd1,
            ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 4)) : 3'd1);
      M_stall  = ($urandom_range(0, 5) == 0);
      M_bubble = ($urandom_range(0, 7) == 0);
      ev = ref_vale(E_icode, E_ifun, E_valA, E_valB, E_valC);
      ec = ref_cnd(E_ifun, mcc);
      ed = (E_icode == 4'h2 && !ec) ? 4'hF : E_dstE;
      #2;
      checks++; if ({e_valE, e_Cnd, e_dstE} !== {ev, ec, ed})
        $display("FAIL rand_comb%0d: got valE=%h cnd=%b dstE=%0h want %h %b %0h", n, e_valE, e_Cnd, e_dstE, ev, ec, ed);
      else passed++;
      if (E_icode == 4'h6 && E_stat == 3'd1 && !bad(m_stat) && !bad(W_stat))
        mcc = ref_flags(E_ifun, E_valA, E_valB);
      if (M_bubble)
        exp_m = {3'd1, 4'h1, 1'b0, 64'd0, 4'hF, 4'hF};
      else if (!M_stall)
        exp_m = {E_stat, E_icode, ec, ev, ed, E_dstM};
      tick;
      got_m = {M_stat, M_icode, M_Cnd, M_valE, M_dstE, M_dstM};
      checks++; if (got_m !== exp_m || cc !== mcc)
        $display("FAIL rand_reg%0d: got m=%h cc=%b want m=%h cc=%b", n, got_m, cc, exp_m, mcc);
      else passed++;
    end
    M_stall = 1'b0; M_bubble = 1'b0;
  endtask

  initial begin
    test_reset;
    test_flags;
    test_conditions;
    test_exceptions;
    test_stack;
    test_controls;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
